// File: rtl/secventiator_faze.sv
// Four-way intersection phase sequencer: N-S / E-W green, yellow, all-red and night yellow.
// Optional pedestrian shortening of E-W green is enabled by defining BUTON_PIETON_EN.
module secventiator_faze #(
  parameter int T_VERDE_NS   = 20,
  parameter int T_VERDE_EW   = 20,
  parameter int T_GALBEN     = 3,
  parameter int T_ROSU_TOTAL = 2,
  parameter int CNT_W        = 8
`ifdef BUTON_PIETON_EN
  ,
  parameter int T_PIETON     = 5
`endif
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       cerere_ew_i,
  input  logic       noapte_i,
`ifdef BUTON_PIETON_EN
  input  logic       buton_pieton_i,
`endif
  output logic       enable_o,
  output logic [1:0] w_n_o,
  output logic [1:0] w_s_o,
  output logic [1:0] w_e_o,
  output logic [1:0] w_v_o,
  output logic       tranzit_ns_o,
  output logic       tranzit_ew_o,
  output logic [2:0] faza_o
);

  typedef enum logic [2:0] {
    ROSU_A    = 3'd0,
    VERDE_NS  = 3'd1,
    GALBEN_NS = 3'd2,
    ROSU_B    = 3'd3,
    VERDE_EW  = 3'd4,
    GALBEN_EW = 3'd5,
    NOAPTE    = 3'd6
  } faza_t;

  localparam logic [CNT_W-1:0] D_ROSU   = CNT_W'(T_ROSU_TOTAL - 1);
  localparam logic [CNT_W-1:0] D_VNS    = CNT_W'(T_VERDE_NS - 1);
  localparam logic [CNT_W-1:0] D_VEW    = CNT_W'(T_VERDE_EW - 1);
  localparam logic [CNT_W-1:0] D_GALBEN = CNT_W'(T_GALBEN - 1);
`ifdef BUTON_PIETON_EN
  localparam logic [CNT_W-1:0] D_PIETON = CNT_W'(T_PIETON - 1);
`endif

  faza_t            stare;
  logic [CNT_W-1:0] cnt;
  logic             cerere_q;
  logic             expira;
  logic             cerere_eff;

  assign expira = tick_i && (cnt == '0);

  // A request arriving on the very cycle the N-S timer expires must already count.
  assign cerere_eff = cerere_q ||
                      (cerere_ew_i && (stare == ROSU_A || stare == VERDE_NS || stare == GALBEN_NS));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stare    <= ROSU_A;
      cnt      <= D_ROSU;
      cerere_q <= 1'b0;
      enable_o <= 1'b0;
    end else begin
      enable_o <= 1'b1;
      cerere_q <= cerere_eff;
      // Free-running decrement saturates at zero; that is what holds N-S green with no demand.
      if (tick_i && cnt != '0) cnt <= cnt - CNT_W'(1);
      case (stare)
        ROSU_A: begin
          if (expira) begin
            if (noapte_i) begin
              stare <= NOAPTE;
              cnt   <= '0;
            end else begin
              stare <= VERDE_NS;
              cnt   <= D_VNS;
            end
          end
        end
        VERDE_NS: begin
          if (expira && cerere_eff) begin
            stare <= GALBEN_NS;
            cnt   <= D_GALBEN;
          end
        end
        GALBEN_NS: begin
          if (expira) begin
            stare <= ROSU_B;
            cnt   <= D_ROSU;
          end
        end
        ROSU_B: begin
          if (expira) begin
            cerere_q <= 1'b0;
            if (noapte_i) begin
              stare <= NOAPTE;
              cnt   <= '0;
            end else begin
              stare <= VERDE_EW;
              cnt   <= D_VEW;
            end
          end
        end
        VERDE_EW: begin
          if (expira) begin
            stare <= GALBEN_EW;
            cnt   <= D_GALBEN;
          end
`ifdef BUTON_PIETON_EN
          else if (buton_pieton_i && cnt > D_PIETON) begin
            cnt <= D_PIETON;
          end
`endif
        end
        GALBEN_EW: begin
          if (expira) begin
            stare <= ROSU_A;
            cnt   <= D_ROSU;
          end
        end
        NOAPTE: begin
          if (!noapte_i) begin
            stare <= ROSU_A;
            cnt   <= D_ROSU;
          end
        end
        default: begin
          stare <= ROSU_A;
          cnt   <= D_ROSU;
        end
      endcase
    end
  end

  always_comb begin
    w_n_o        = 2'b11;
    w_s_o        = 2'b11;
    w_e_o        = 2'b11;
    w_v_o        = 2'b11;
    tranzit_ns_o = 1'b0;
    tranzit_ew_o = 1'b0;
    faza_o       = stare;
    case (stare)
      VERDE_NS: begin
        w_n_o = 2'b10; w_s_o = 2'b10; w_e_o = 2'b00; w_v_o = 2'b00;
      end
      GALBEN_NS: begin
        w_n_o = 2'b01; w_s_o = 2'b01; w_e_o = 2'b00; w_v_o = 2'b00;
      end
      VERDE_EW: begin
        w_n_o = 2'b00; w_s_o = 2'b00; w_e_o = 2'b10; w_v_o = 2'b10;
      end
      GALBEN_EW: begin
        w_n_o = 2'b00; w_s_o = 2'b00; w_e_o = 2'b01; w_v_o = 2'b01;
      end
      NOAPTE: begin
        w_n_o = 2'b00; w_s_o = 2'b00; w_e_o = 2'b00; w_v_o = 2'b00;
        tranzit_ns_o = 1'b1;
        tranzit_ew_o = 1'b1;
      end
      default: begin
        w_n_o = 2'b11; w_s_o = 2'b11; w_e_o = 2'b11; w_v_o = 2'b11;
      end
    endcase
  end

endmodule

// File: tb/tb_secventiator_faze.sv
// Bench for secventiator_faze: phase/elapsed-tick reference model, per-cycle compare, directed and random stimulus.
module tb_secventiator_faze;

  localparam int T_VNS  = 20;
  localparam int T_VEW  = 20;
  localparam int T_GAL  = 3;
  localparam int T_ROSU = 2;
  localparam int T_PIE  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic cerere = 1'b0;
  logic noapte = 1'b0;
  logic buton = 1'b0;
  logic       enable;
  logic [1:0] w_n, w_s, w_e, w_v;
  logic       tr_ns, tr_ew;
  logic [2:0] faza;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  secventiator_faze dut (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .cerere_ew_i(cerere), .noapte_i(noapte),
`ifdef BUTON_PIETON_EN
    .buton_pieton_i(buton),
`endif
    .enable_o(enable), .w_n_o(w_n), .w_s_o(w_s), .w_e_o(w_e), .w_v_o(w_v),
    .tranzit_ns_o(tr_ns), .tranzit_ew_o(tr_ew), .faza_o(faza)
  );

  // Reference model: current phase, ticks elapsed in it, tick length of this phase, demand flag.
  int ph = 0, el = 0, lim = T_ROSU;
  bit lat = 0, en = 0, armed = 0;

  function automatic int durata(input int p);
    case (p)
      1: return T_VNS;
      2, 5: return T_GAL;
      4: return T_VEW;
      default: return T_ROSU;
    endcase
  endfunction

  function automatic logic [1:0] cod_ns(input int p);
    case (p)
      1: return 2'b10;
      2: return 2'b01;
      4, 5, 6: return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [1:0] cod_ew(input int p);
    case (p)
      4: return 2'b10;
      5: return 2'b01;
      1, 2, 6: return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  always @(posedge clk) begin
    int  nph;
    bit  nlat;
    if (rst) begin
      ph = 0; el = 0; lim = T_ROSU; lat = 0; en = 0; armed = 1;
    end else begin
      en   = 1;
      nlat = lat | (cerere && ph <= 2);
      nph  = ph;
      if (ph == 6) begin
        if (!noapte) nph = 0;
      end
`ifdef BUTON_PIETON_EN
      else if (ph == 4 && buton && (lim - el) > T_PIE) begin
        lim = el + T_PIE;
      end
`endif
      else if (tick) begin
        if (el + 1 < lim) el++;
        else begin
          case (ph)
            0: nph = noapte ? 6 : 1;
            1: if (nlat) nph = 2;
            2: nph = 3;
            3: begin nph = noapte ? 6 : 4; nlat = 0; end
            4: nph = 5;
            5: nph = 0;
            default: nph = 0;
          endcase
        end
      end
      if (nph != ph) begin
        el  = 0;
        lim = durata(nph);
      end
      ph  = nph;
      lat = nlat;
    end
  end

  always @(negedge clk) begin
    logic [12:0] act, expv;
    if (armed) begin
      act  = {enable, faza, w_n, w_s, w_e, w_v, tr_ns, tr_ew};
      expv = {en, 3'(ph), cod_ns(ph), cod_ns(ph), cod_ew(ph), cod_ew(ph), ph == 6, ph == 6};
      vectors++;
      if (act !== expv) begin
        miscompares++;
        $display("FAIL outputs t=%0t got=%b expected=%b (en,faza,wn,ws,we,wv,trns,trew)", $time, act, expv);
      end
    end
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic cyc(input bit t);
    @(negedge clk);
    tick = t;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1);
      repeat (9) cyc(1'b0);
    end
  endtask

  task automatic pulse_cerere();
    @(negedge clk); cerere = 1'b1; tick = 1'b0;
    @(negedge clk); cerere = 1'b0;
  endtask

  task automatic press();
    @(negedge clk); buton = 1'b1; tick = 1'b0;
    @(negedge clk); buton = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_faza", 4'(faza), 4'd0);
    check("reset_enable", 4'(enable), 4'd0);
    check("reset_w_n", 4'(w_n), 4'b0011);
    rst = 1'b0;
    cyc(1'b0);
    check("enable_after_reset", 4'(enable), 4'd1);
    ticks(1);
    check("rosu_a_tick1", 4'(faza), 4'd0);
    ticks(1);
    check("verde_ns_faza", 4'(faza), 4'd1);
    check("verde_ns_w_n", 4'(w_n), 4'b0010);
    check("verde_ns_w_e", 4'(w_e), 4'b0000);
    ticks(40);
    check("verde_ns_hold40", 4'(faza), 4'd1);
    pulse_cerere();
    ticks(1); check("galben_ns", 4'(faza), 4'd2);
    ticks(3); check("rosu_b", 4'(faza), 4'd3);
    ticks(2); check("verde_ew", 4'(faza), 4'd4);
    ticks(19); check("verde_ew_19", 4'(faza), 4'd4);
    ticks(1); check("galben_ew", 4'(faza), 4'd5);
    ticks(3); check("rosu_a_again", 4'(faza), 4'd0);
    ticks(2); check("verde_ns_again", 4'(faza), 4'd1);
    ticks(4); pulse_cerere(); ticks(15);
    check("verde_ns_tick19", 4'(faza), 4'd1);
    ticks(1); check("galben_ns_tick20", 4'(faza), 4'd2);
    ticks(3); ticks(2); check("verde_ew_2", 4'(faza), 4'd4);
    @(negedge clk); noapte = 1'b1;
    ticks(20); check("night_galben_ew", 4'(faza), 4'd5);
    ticks(3); check("night_rosu_a", 4'(faza), 4'd0);
    ticks(2); check("noapte", 4'(faza), 4'd6);
    check("noapte_w_e", 4'(w_e), 4'b0000);
    check("noapte_tranzit", {2'b00, tr_ns, tr_ew}, 4'b0011);
    @(negedge clk); noapte = 1'b0;
    @(negedge clk); check("noapte_exit", 4'(faza), 4'd0);
    ticks(2); check("verde_ns_after_night", 4'(faza), 4'd1);
    ticks(20); check("latch_cleared", 4'(faza), 4'd1);
    pulse_cerere();
    ticks(1); check("galben_ns_3", 4'(faza), 4'd2);
    ticks(5); ticks(3); check("verde_ew_3", 4'(faza), 4'd4);
    repeat (1000) cyc(1'b0);
    check("no_tick_hold", 4'(faza), 4'd4);
    check("no_tick_w_e", 4'(w_e), 4'b0010);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midreset_faza", 4'(faza), 4'd0);
    check("midreset_enable", 4'(enable), 4'd0);
    check("midreset_w_e", 4'(w_e), 4'b0011);
    ticks(1); check("midreset_rosu", 4'(faza), 4'd0);
    ticks(1); check("midreset_verde_ns", 4'(faza), 4'd1);
`ifdef BUTON_PIETON_EN
    pulse_cerere(); ticks(20); ticks(5);
    check("pieton_verde_ew", 4'(faza), 4'd4);
    ticks(2); press(); ticks(4);
    check("pieton_tick6", 4'(faza), 4'd4);
    ticks(1); check("pieton_tick7", 4'(faza), 4'd5);
    ticks(3); ticks(2); pulse_cerere(); ticks(20); ticks(5);
    ticks(17); press(); ticks(2);
    check("pieton_late_press", 4'(faza), 4'd4);
    ticks(1); check("pieton_late_end", 4'(faza), 4'd5);
`endif
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      tick   = ($urandom_range(0, 3) == 0);
      cerere = ($urandom_range(0, 19) == 0);
      buton  = ($urandom_range(0, 29) == 0);
      rst    = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 299) == 0) noapte = ~noapte;
    end
    @(negedge clk);
    rst = 1'b0; tick = 1'b0; cerere = 1'b0; buton = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/secventiator_faze.md
Name: secventiator_faze

Overview:
- Phase sequencer for the four-way intersection; sits directly upstream of the per-approach light decoders.
- Drives their enable, 2-bit light code and transit flag.
- Alternates N-S and E-W traffic through green, yellow and all-red phases, timed in ticks of an external 1 Hz strobe.
- E-W green is vehicle-actuated. A night mode puts every approach in steady yellow.

Parameters:
- T_VERDE_NS, 20, N-S green minimum duration in ticks.
- T_VERDE_EW, 20, E-W green duration in ticks (fixed).
- T_GALBEN, 3, yellow duration in ticks.
- T_ROSU_TOTAL, 2, all-red clearance duration in ticks.
- CNT_W, 8, tick counter width. All T_* values must be ≥1 and ≤2^CNT_W.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-high.
- tick_i  in  1  one-cycle timing strobe (1 Hz).
- cerere_ew_i  in  1  E-W vehicle-presence sensor, level or pulse.
- noapte_i  in  1  night-mode request, level.
- enable_o  out  1  enable to all light decoders.
- w_n_o, w_s_o, w_e_o, w_v_o  out  2 each  light code per approach: 00 red, 01 yellow, 10 green, 11 all-red.
- tranzit_ns_o, tranzit_ew_o  out  1 each  force-yellow flag to the N/S and E/V decoders.
- faza_o  out  3  current state code, for debug and monitoring.

Behaviour:
- Clock and reset: single clock clk_i. rst_i is synchronous and active-high and has priority over all other inputs.
- Reset state:
  - state = ROSU_A, counter = T_ROSU_TOTAL-1, cerere latch = 0.
  - enable_o = 0, all w_* = 11, tranzit_* = 0, faza_o = 0.
- enable_o is registered: 0 during reset, 1 from the first edge with rst_i low.
- States (faza_o code): ROSU_A 0, VERDE_NS 1, GALBEN_NS 2, ROSU_B 3, VERDE_EW 4, GALBEN_EW 5, NOAPTE 6.
- Outputs are decoded combinationally from the state register, so they change on the same edge as the state.
  - VERDE_NS: w_n/w_s = 10, w_e/w_v = 00.
  - GALBEN_NS: w_n/w_s = 01, w_e/w_v = 00.
  - VERDE_EW: w_e/w_v = 10, w_n/w_s = 00.
  - GALBEN_EW: w_e/w_v = 01, w_n/w_s = 00.
  - ROSU_A and ROSU_B: all w = 11.
  - NOAPTE: all w = 00, tranzit_ns_o = tranzit_ew_o = 1. tranzit_* is 0 in every other state.
- Timer:
  - On entry to a state the counter loads duration-1.
  - It decrements only on cycles with tick_i=1.
  - A timed exit occurs on the edge where tick_i=1 and counter==0, so each state lasts exactly duration ticks.
  - With tick_i=0, state and counter hold.
- Transitions:
  - ROSU_A → VERDE_NS.
  - VERDE_NS → GALBEN_NS, only when the timer has expired AND the cerere latch is 1. If the timer expires with latch=0, the counter stays at 0 and the state holds. The exit then fires on the first tick_i with latch=1.
  - GALBEN_NS → ROSU_B.
  - ROSU_B → VERDE_EW. The cerere latch clears on this edge.
  - VERDE_EW → GALBEN_EW.
  - GALBEN_EW → ROSU_A.
- Cerere latch:
  - Set by cerere_ew_i=1 in any cycle while in ROSU_A, VERDE_NS or GALBEN_NS.
  - A set on the same cycle as a timer-expiry tick counts immediately.
  - Ignored in the E-W states and in NOAPTE.
- Night mode:
  - noapte_i is sampled only at the timed exit of ROSU_A or ROSU_B; if it is 1 there, the next state is NOAPTE instead of the green.
  - noapte_i raised during a green finishes the normal green → yellow → all-red path first.
  - NOAPTE exits when noapte_i=0 (no tick needed), to ROSU_A with the counter loaded.
- Simultaneous rst_i and tick_i: reset wins.
- Reset mid-phase: reset values on the next edge.

Optional Feature:
- Macro: BUTON_PIETON_EN.
- Defined:
  - Adds input buton_pieton_i (1 bit) and parameter T_PIETON (default 5).
  - A press in VERDE_EW with counter > T_PIETON-1 reloads the counter to T_PIETON-1, shortening E-W green so pedestrians cross sooner.
  - Presses in any other state, or with counter ≤ T_PIETON-1, have no effect.
- Undefined: the port and parameter are absent and E-W green is always T_VERDE_EW ticks.

Test Plan:
- Reset, then tick_i every 10 cycles → all w=11 for 2 ticks; then w_n=10, w_e=00, faza_o=1; enable_o=1 from the first post-reset edge.
- cerere_ew_i=0 for 40 ticks → VERDE_NS held for all 40. Pulse cerere_ew_i → next tick GALBEN_NS (3 ticks), ROSU_B (2), VERDE_EW (exactly 20), GALBEN_EW (3), ROSU_A.
- cerere_ew_i pulse at tick 5 of VERDE_NS → GALBEN_NS entered exactly at tick 20; latch reads 0 after ROSU_B → VERDE_EW.
- noapte_i=1 during VERDE_EW → finishes GALBEN_EW and ROSU_A, then NOAPTE (all w=00, both tranzit=1). Drop noapte_i → next edge ROSU_A, 2 ticks, then VERDE_NS.
- rst_i for one cycle mid-VERDE_EW → next edge all w=11, enable_o=0, faza_o=0. Sequence restarts with a 2-tick all-red.
- tick_i=0 for 1000 cycles in VERDE_EW → no change to state or outputs.
- BUTON_PIETON_EN: press at VERDE_EW tick 2 → green ends after 2+5=7 ticks total. Press with 3 ticks remaining → no change.
